// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter family.
package counter_pkg;

  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } counter_mode_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count for the up/down modulo counter: load clamp, step,
// wrap/saturate at the range ends, and the terminal-count event.
module counter_next
  import counter_pkg::*;
#(
  parameter int N   = 8,
  parameter int MAX = 2**N-1
) (
  input  logic [N-1:0]  count_i,
  input  logic          ena_i,
  input  logic          up_i,
  input  counter_mode_t mode_i,
  input  logic          load_i,
  input  logic [N-1:0]  load_value_i,
  output logic [N-1:0]  count_o,
  output logic          tc_o
);

  localparam logic [N:0]   MAX_EXT = (N+1)'(MAX);
  localparam logic [N-1:0] MAX_N   = N'(MAX);

  // One extra bit so MAX = 2**N-1 overflows visibly instead of wrapping early.
  logic [N:0] sum_s;
  logic [N:0] diff_s;

  // Next-state selection with load over enable; a blocked or wrapping step raises tc.
  always_comb begin
    sum_s   = {1'b0, count_i} + {{N{1'b0}}, 1'b1};
    diff_s  = {1'b0, count_i} - {{N{1'b0}}, 1'b1};
    count_o = count_i;
    tc_o    = 1'b0;
    if (load_i) begin
      if ({1'b0, load_value_i} > MAX_EXT) begin
        count_o = MAX_N;
      end else begin
        count_o = load_value_i;
      end
    end else if (ena_i) begin
      if (up_i) begin
        if (sum_s > MAX_EXT) begin
          tc_o = 1'b1;
          case (mode_i)
            WRAP:     count_o = {N{1'b0}};
            SATURATE: count_o = count_i;
            default:  count_o = count_i;
          endcase
        end else begin
          count_o = sum_s[N-1:0];
        end
      end else begin
        // Borrow out of the extra bit means the step went below zero.
        if (diff_s[N]) begin
          tc_o = 1'b1;
          case (mode_i)
            WRAP:     count_o = MAX_N;
            SATURATE: count_o = count_i;
            default:  count_o = count_i;
          endcase
        end else begin
          count_o = diff_s[N-1:0];
        end
      end
    end else begin
      count_o = count_i;
      tc_o    = 1'b0;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate behaviour, registered
// terminal-count pulse and sticky over/underflow flag.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N   = 8,
  parameter int MAX = 2**N-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          up,
  input  counter_mode_t mode,
  input  logic          load,
  input  logic [N-1:0]  load_value,
  input  logic          clr_ovf,
  output logic [N-1:0]  count,
  output logic          tc,
  output logic          ovf
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         tc_q;
  logic         tc_d;
  logic         ovf_q;
  logic         ovf_d;

  counter_next #(
    .N   (N),
    .MAX (MAX)
  ) u_next (
    .count_i      (count_q),
    .ena_i        (ena),
    .up_i         (up),
    .mode_i       (mode),
    .load_i       (load),
    .load_value_i (load_value),
    .count_o      (count_d),
    .tc_o         (tc_d)
  );

  // A new set event beats a simultaneous clear so no overflow is ever lost.
  always_comb begin
    ovf_d = 1'b0;
    if (tc_d) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // All counter state; reset overrides load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {N{1'b0}};
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: N=4/MAX=9 instance for wrap, saturate, load clamp, ovf and
// reset cases; N=8 default-MAX instance for full-range wrap.
module tb_updown_mod_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_ena, a_up, a_load, a_clr;
  counter_mode_t a_mode;
  logic [3:0]    a_lv, a_count;
  logic          a_tc, a_ovf;

  logic          b_rst, b_ena, b_up, b_load, b_clr;
  counter_mode_t b_mode;
  logic [7:0]    b_lv, b_count;
  logic          b_tc, b_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  updown_mod_counter #(.N(4), .MAX(9)) u_a (
    .clk(clk), .rst(a_rst), .ena(a_ena), .up(a_up), .mode(a_mode),
    .load(a_load), .load_value(a_lv), .clr_ovf(a_clr),
    .count(a_count), .tc(a_tc), .ovf(a_ovf)
  );

  updown_mod_counter #(.N(8)) u_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .up(b_up), .mode(b_mode),
    .load(b_load), .load_value(b_lv), .clr_ovf(b_clr),
    .count(b_count), .tc(b_tc), .ovf(b_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input int t, input int o);
    check_val({tag, ".count"}, 32'(a_count), c);
    check_val({tag, ".tc"},    32'(a_tc),    t);
    check_val({tag, ".ovf"},   32'(a_ovf),   o);
  endtask

  // Expected counts for 12 enabled WRAP up steps from 0 with MAX=9.
  int wrap_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int wrap_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int wrap_ovf[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int sat_cnt [4]  = '{1, 0, 0, 0};
  int sat_tc  [4]  = '{0, 0, 1, 1};

  initial begin
    a_rst = 1'b1; a_ena = 1'b1; a_up = 1'b1; a_load = 1'b1; a_clr = 1'b0;
    a_mode = WRAP; a_lv = 4'd5;
    b_rst = 1'b1; b_ena = 1'b0; b_up = 1'b1; b_load = 1'b0; b_clr = 1'b0;
    b_mode = WRAP; b_lv = 8'd0;
    #2;
    tick();
    chk_a("reset", 0, 0, 0);

    // Wrap up for 12 cycles.
    a_rst = 1'b0; a_load = 1'b0; a_ena = 1'b1; a_up = 1'b1; a_mode = WRAP;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_a($sformatf("wrap%0d", i), wrap_cnt[i], wrap_tc[i], wrap_ovf[i]);
    end

    // Hold with clear only.
    a_ena = 1'b0; a_clr = 1'b1;
    tick();
    chk_a("clr_hold", 2, 0, 0);

    // Saturate down from 2.
    a_clr = 1'b0; a_ena = 1'b1; a_up = 1'b0; a_mode = SATURATE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("satdn%0d", i), sat_cnt[i], sat_tc[i], (i >= 2) ? 1 : 0);
    end

    // Load clamp beats enable, then wrap from MAX.
    a_mode = WRAP; a_up = 1'b1; a_load = 1'b1; a_lv = 4'd15; a_ena = 1'b1;
    tick();
    chk_a("load_clamp", 9, 0, 1);
    a_load = 1'b0;
    tick();
    chk_a("load_wrap", 0, 1, 1);

    // Saturate up at MAX.
    a_load = 1'b1; a_lv = 4'd9; a_ena = 1'b0;
    tick();
    a_load = 1'b0; a_ena = 1'b1; a_mode = SATURATE;
    tick();
    chk_a("satup", 9, 1, 1);

    // Wrap event with simultaneous clear keeps ovf; lone clear drops it.
    a_mode = WRAP; a_clr = 1'b1;
    tick();
    chk_a("clr_vs_set", 0, 1, 1);
    a_ena = 1'b0;
    tick();
    chk_a("clr_alone", 0, 0, 0);

    // Reset at count 7 with ena and load asserted.
    a_clr = 1'b0; a_load = 1'b1; a_lv = 4'd9;
    tick();
    a_load = 1'b0; a_ena = 1'b1;
    tick();
    a_ena = 1'b0; a_load = 1'b1; a_lv = 4'd7;
    tick();
    chk_a("pre_rst", 7, 0, 1);
    a_rst = 1'b1; a_ena = 1'b1; a_load = 1'b1; a_lv = 4'd3;
    tick();
    chk_a("rst_mid", 0, 0, 0);

    // Reset on the edge where a wrap would happen leaves no tc afterwards.
    a_rst = 1'b0; a_ena = 1'b0; a_load = 1'b1; a_lv = 4'd9;
    tick();
    a_load = 1'b0; a_ena = 1'b1; a_rst = 1'b1;
    tick();
    chk_a("rst_wrap", 0, 0, 0);
    a_rst = 1'b0; a_ena = 1'b0;
    tick();
    chk_a("post_rst", 0, 0, 0);

    // N=8 default MAX full-range wrap.
    b_rst = 1'b0; b_load = 1'b1; b_lv = 8'd255;
    tick();
    check_val("b_load", 32'(b_count), 255);
    b_load = 1'b0; b_ena = 1'b1; b_up = 1'b1;
    tick();
    check_val("b_up.count", 32'(b_count), 0);
    check_val("b_up.tc",    32'(b_tc),    1);
    b_up = 1'b0;
    tick();
    check_val("b_dn.count", 32'(b_count), 255);
    check_val("b_dn.tc",    32'(b_tc),    1);
    check_val("b_dn.ovf",   32'(b_ovf),   1);
    b_ena = 1'b0;
    tick();
    check_val("b_hold.count", 32'(b_count), 255);
    check_val("b_hold.tc",    32'(b_tc),    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
